// File: rtl/gpout_serial_pkg.sv
// Shared types and width helpers for the GPOUT serial transmitter.
package gpout_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gpout_serial_tx_gpout.sv
// GPOUT pad cell: buffers the registered pad level onto the output pad.
module gpout_serial_tx_gpout (
  input  logic A,
  output logic Y
);

  assign Y = A;

endmodule

// File: rtl/gpout_serial_tx.sv
// Framed LSB-first asynchronous serializer (start, DATA_W data bits, stop)
// driving the GPOUT pad from a registered level.
module gpout_serial_tx
  import gpout_serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy,
  output logic [0:0]        gfpga_pad_GPOUT_PAD
);

  localparam int IDX_W = width_of(DATA_W);
  localparam int CNT_W = width_of(CLKS_PER_BIT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e         r_state;
  logic [DATA_W-1:0] r_shift;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [CNT_W-1:0]  r_baud;
  logic              r_pad;

  logic              w_bit_end;
  logic              w_accept;
  logic [DATA_W-1:0] w_shift_next;

  assign w_bit_end    = (r_baud == CNT_LAST);
  assign w_shift_next = r_shift >> 1;

  // Ready in the final stop cycle lets the next start bit follow with no gap.
  assign tx_ready = !reset &&
                    ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));
  assign w_accept = tx_valid && tx_ready;
  assign busy     = (r_state != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_baud    <= '0;
      r_pad     <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_baud <= '0;
          if (w_accept) begin
            r_shift <= tx_data;
            r_state <= ST_START;
            r_pad   <= 1'b0;
          end
        end

        ST_START: begin
          if (w_bit_end) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_state   <= ST_DATA;
            r_pad     <= r_shift[0];
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        ST_DATA: begin
          if (w_bit_end) begin
            r_baud  <= '0;
            r_shift <= w_shift_next;
            if (r_bit_idx == IDX_LAST) begin
              r_state <= ST_STOP;
              r_pad   <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_pad     <= w_shift_next[0];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        ST_STOP: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (w_accept) begin
              r_shift <= tx_data;
              r_state <= ST_START;
              r_pad   <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_pad   <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_pad   <= 1'b1;
        end
      endcase
    end
  end

  gpout_serial_tx_gpout u_gpout (
    .A (r_pad),
    .Y (gfpga_pad_GPOUT_PAD[0])
  );

endmodule

// File: tb/tb_gpout_serial_tx.sv
// Bench for gpout_serial_tx: a waveform-queue model per instance checked every
// cycle, literal frame expectations, and a mid-bit UART decoder for a long run.
module tb_gpout_serial_tx;

  localparam int W8 = 8;
  localparam int C8 = 4;

  logic clk;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Instance A: DATA_W=8, CLKS_PER_BIT=4
  logic       rst8, v8, ready8, busy8;
  logic [7:0] d8;
  logic [0:0] pad8;
  // Instance B: DATA_W=1, CLKS_PER_BIT=1
  logic       rst1, v1, ready1, busy1;
  logic [0:0] d1;
  logic [0:0] pad1;

  gpout_serial_tx #(.DATA_W(W8), .CLKS_PER_BIT(C8)) u_dut8 (
    .clk                 (clk),
    .reset               (rst8),
    .tx_data             (d8),
    .tx_valid            (v8),
    .tx_ready            (ready8),
    .busy                (busy8),
    .gfpga_pad_GPOUT_PAD (pad8)
  );

  gpout_serial_tx #(.DATA_W(1), .CLKS_PER_BIT(1)) u_dut1 (
    .clk                 (clk),
    .reset               (rst1),
    .tx_data             (d1),
    .tx_valid            (v1),
    .tx_ready            (ready1),
    .busy                (busy1),
    .gfpga_pad_GPOUT_PAD (pad1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Model: queue of pad levels still to be shown, front = current cycle.
  bit   q8[$];
  bit   q1[$];
  bit   acc8, acc1;
  bit   dec_en = 1'b0;
  logic [7:0] sent_q[$];

  always @(posedge clk) begin
    bit rdy;
    rdy  = !rst8 && (q8.size() <= 1);
    acc8 = v8 && rdy;
    if (rst8) q8.delete();
    else begin
      if (q8.size() > 0) void'(q8.pop_front());
      if (acc8) begin
        for (int c = 0; c < C8; c++) q8.push_back(1'b0);
        for (int b = 0; b < W8; b++)
          for (int c = 0; c < C8; c++) q8.push_back(d8[b]);
        for (int c = 0; c < C8; c++) q8.push_back(1'b1);
        if (dec_en) sent_q.push_back(d8);
      end
    end
  end

  always @(posedge clk) begin
    bit rdy;
    rdy  = !rst1 && (q1.size() <= 1);
    acc1 = v1 && rdy;
    if (rst1) q1.delete();
    else begin
      if (q1.size() > 0) void'(q1.pop_front());
      if (acc1) begin
        q1.push_back(1'b0);
        q1.push_back(d1[0]);
        q1.push_back(1'b1);
      end
    end
  end

  // Per-cycle comparison of {pad, busy, ready} against the model.
  always @(negedge clk) begin
    logic e_pad8, e_pad1;
    e_pad8 = (q8.size() != 0) ? q8[0] : 1'b1;
    e_pad1 = (q1.size() != 0) ? q1[0] : 1'b1;
    check("cycle_dut8", {pad8, busy8, ready8},
          {e_pad8, q8.size() != 0, !rst8 && (q8.size() <= 1)});
    check("cycle_dut1", {pad1, busy1, ready1},
          {e_pad1, q1.size() != 0, !rst1 && (q1.size() <= 1)});
  end

  // Reference UART receiver: detect start, sample each bit at its middle.
  int         dec_cnt;
  bit         dec_active = 1'b0;
  logic [7:0] dec_sh;
  int         n_rx = 0;

  always @(negedge clk) begin
    if (!dec_en) dec_active = 1'b0;
    else if (!dec_active) begin
      if (pad8 == 1'b0) begin
        dec_active = 1'b1;
        dec_cnt    = 0;
      end
    end else begin
      dec_cnt++;
      if ((dec_cnt % C8 == C8 / 2) && (dec_cnt / C8 >= 1) && (dec_cnt / C8 <= W8))
        dec_sh[dec_cnt / C8 - 1] = pad8;
      if (dec_cnt == (W8 + 1) * C8 + C8 / 2) begin
        check("uart_stop_bit", pad8, 1'b1);
        check("uart_word_expected", sent_q.size() != 0, 1'b1);
        if (sent_q.size() != 0) check("uart_word", dec_sh, sent_q.pop_front());
        n_rx++;
        dec_active = 1'b0;
      end
    end
  end

  task automatic send8(input logic [7:0] d, input int max_cyc);
    bit ok;
    ok = 1'b0;
    @(negedge clk); #1;
    v8 = 1'b1;
    d8 = d;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(posedge clk); #1;
      ok = acc8;
    end
    v8 = 1'b0;
    check("send8_accepted", ok, 1'b1);
  endtask

  task automatic wait_accept1(input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(posedge clk); #1;
      ok = acc1;
    end
    check("send1_accepted", ok, 1'b1);
  endtask

  task automatic capture40(output logic [39:0] cap);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cap[i] = pad8[0];
    end
  endtask

  initial begin
    logic [39:0] cap;
    logic [5:0]  cap1;
    bit          ok;
    int          cyc, rdy_cnt;

    rst8 = 1'b1; v8 = 1'b0; d8 = '0;
    rst1 = 1'b1; v1 = 1'b0; d1 = '0;
    repeat (3) @(negedge clk);
    #1;
    rst8 = 1'b0;
    rst1 = 1'b0;
    #1;
    check("reset_release_dut8", {pad8, busy8, ready8}, 3'b101);
    check("reset_release_dut1", {pad1, busy1, ready1}, 3'b101);

    // 0xA5: 0,1,0,1,0,0,1,0,1,1 with each bit held four cycles.
    send8(8'hA5, 5);
    capture40(cap);
    check("frame_a5", cap, 40'hFF0F00F0F0);
    @(negedge clk);
    check("a5_idle_after", {pad8, ready8}, 2'b11);

    // Back-to-back 0x00 then 0xFF with valid held high.
    @(negedge clk); #1;
    v8 = 1'b1;
    d8 = 8'h00;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(posedge clk); #1;
      ok = acc8;
    end
    check("b2b_first_accept", ok, 1'b1);
    d8 = 8'hFF;
    ok = 1'b0; cyc = 0; rdy_cnt = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      rdy_cnt += int'(ready8);
      @(posedge clk); #1;
      cyc++;
      ok = acc8;
    end
    v8 = 1'b0;
    check("b2b_second_accept", ok, 1'b1);
    check("b2b_frame_cycles", cyc, 40);
    check("b2b_ready_pulses", rdy_cnt, 1);
    @(negedge clk);
    check("b2b_second_start", pad8, 1'b0);
    repeat (45) @(negedge clk);

    // 0x81 in flight while 0x3C is presented mid-frame.
    send8(8'h81, 5);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cap[i] = pad8[0];
      if (i == 9) begin
        #1;
        v8 = 1'b1;
        d8 = 8'h3C;
      end
    end
    @(posedge clk); #1;
    check("hold_3c_accept_at_stop_end", acc8, 1'b1);
    v8 = 1'b0;
    check("frame_81", cap, 40'hFF000000F0);
    repeat (45) @(negedge clk);

    // Reset during data bit 3, with valid already presenting 0x55.
    send8(8'h0F, 5);
    repeat (18) @(negedge clk);
    #1;
    rst8 = 1'b1;
    v8   = 1'b1;
    d8   = 8'h55;
    @(negedge clk);
    check("reset_mid_frame", {pad8, busy8}, 2'b10);
    check("reset_blocks_accept", acc8, 1'b0);
    #1;
    rst8 = 1'b0;
    #1;
    check("ready_after_release", ready8, 1'b1);
    @(posedge clk); #1;
    check("accept_after_release", acc8, 1'b1);
    v8 = 1'b0;
    capture40(cap);
    check("frame_55", cap, 40'hF0F0F0F0F0);
    repeat (5) @(negedge clk);

    // DATA_W=1, CLKS_PER_BIT=1: single word then back-to-back 0,1.
    @(negedge clk); #1;
    v1 = 1'b1;
    d1 = 1'b1;
    wait_accept1(5);
    v1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cap1[i] = pad1[0];
    end
    check("frame_w1_one", cap1[2:0], 3'b110);
    repeat (2) @(negedge clk);
    #1;
    v1 = 1'b1;
    d1 = 1'b0;
    wait_accept1(5);
    d1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cap1[i] = pad1[0];
      if (i == 2) begin
        @(posedge clk); #1;
        check("w1_b2b_accept", acc1, 1'b1);
        v1 = 1'b0;
      end
    end
    check("frame_w1_b2b", cap1, 6'b110100);

    // 1000 random words with random valid gaps through the UART decoder.
    repeat (5) @(negedge clk);
    dec_en = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send8(8'($urandom_range(0, 255)), 60);
    end
    repeat (50) @(negedge clk);
    check("uart_word_count", n_rx, 1000);
    check("uart_leftover", sent_q.size(), 0);
    dec_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
